// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: error bit positions, field widths and
// the layout of one buffered entry.
package uart_pkg;

    localparam int ERR_PARITY    = 0;
    localparam int ERR_START     = 1;
    localparam int ERR_STOP      = 2;
    localparam int UART_DATA_W   = 8;
    localparam int UART_ERR_W    = 3;
    localparam int RXBUF_ENTRY_W = UART_DATA_W + UART_ERR_W;

    typedef struct packed {
        logic [UART_ERR_W-1:0]  err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    function automatic logic has_error(input logic [UART_ERR_W-1:0] err);
        return err[ERR_PARITY] | err[ERR_START] | err[ERR_STOP];
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Storage array for the receive buffer: synchronous write, asynchronous read,
// contents deliberately left unreset.
module rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [RXBUF_ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic [RXBUF_ENTRY_W-1:0] rdata
);

    logic [RXBUF_ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive frame buffer: one capture per done_flag rise, byte+error tag queued in
// a fall-through FIFO with valid/ready read port and sticky overflow.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter bit DROP_ERRORED = 1'b0
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     done_flag,
    input  logic [UART_DATA_W-1:0]   rx_data,
    input  logic [UART_ERR_W-1:0]    rx_error,
    input  logic                     rd_ready,
    input  logic                     clr_overflow,
    output logic                     rd_valid,
    output logic [UART_DATA_W-1:0]   rd_data,
    output logic [UART_ERR_W-1:0]    rd_error,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          done_q;
    logic          cap;
    logic          push;
    logic          pop;
    logic          wr_en;
    rx_entry_t     wr_entry;
    rx_entry_t     rd_entry;

    // Data is sampled one clock after the rise so the Rx error flags have settled.
    assign push  = cap & ~(DROP_ERRORED & has_error(rx_error));
    assign pop   = rd_valid & rd_ready;
    assign wr_en = push & (~full | pop);

    assign wr_entry.data = rx_data;
    assign wr_entry.err  = rx_error;

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            done_q   <= 1'b0;
            cap      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            done_q <= done_flag;
            cap    <= done_flag & ~done_q;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr_en) begin
                count <= count - 1'b1;
            end
            // A lost frame wins over a same-cycle clear.
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : rd_entry.data;
    assign rd_error = empty ? '0 : rd_entry.err;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench: two buffers (keep / drop errored frames) on shared stimulus,
// compared against queue-based reference models plus directed vectors.
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          rst;
    logic          done_flag;
    logic [7:0]    rx_data;
    logic [2:0]    rx_error;
    logic          rd_ready;
    logic          clr_overflow;

    logic          rd_valid0, rd_valid1;
    logic [7:0]    rd_data0, rd_data1;
    logic [2:0]    rd_error0, rd_error1;
    logic [CW-1:0] count0, count1;
    logic          full0, full1, empty0, empty1, overflow0, overflow1;

    uart_rx_buffer #(.DEPTH(DEPTH), .DROP_ERRORED(1'b0)) dut_keep (
        .clock(clock), .rst(rst), .done_flag(done_flag), .rx_data(rx_data),
        .rx_error(rx_error), .rd_ready(rd_ready), .clr_overflow(clr_overflow),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_error(rd_error0),
        .count(count0), .full(full0), .empty(empty0), .overflow(overflow0)
    );

    uart_rx_buffer #(.DEPTH(DEPTH), .DROP_ERRORED(1'b1)) dut_drop (
        .clock(clock), .rst(rst), .done_flag(done_flag), .rx_data(rx_data),
        .rx_error(rx_error), .rd_ready(rd_ready), .clr_overflow(clr_overflow),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_error(rd_error1),
        .count(count1), .full(full1), .empty(empty1), .overflow(overflow1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frames as 11-bit {err,data} entries in a queue per buffer.
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    bit          ov0, ov1;
    bit          m_prev, m_cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        ov0 = 0; ov1 = 0; m_prev = 0; m_cap = 0;
    endtask

    task automatic model_step();
        logic [10:0] e;
        bit pop0, pop1, push0, push1, lost0, lost1;
        int n0, n1;
        e = {rx_error, rx_data};
        n0 = q0.size(); n1 = q1.size();
        pop0  = (n0 > 0) && rd_ready;
        pop1  = (n1 > 0) && rd_ready;
        push0 = m_cap;
        push1 = m_cap && (rx_error == 3'b000);
        lost0 = push0 && n0 == DEPTH && !pop0;
        lost1 = push1 && n1 == DEPTH && !pop1;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (push0 && !lost0) q0.push_back(e);
        if (push1 && !lost1) q1.push_back(e);
        ov0 = lost0 ? 1'b1 : (clr_overflow ? 1'b0 : ov0);
        ov1 = lost1 ? 1'b1 : (clr_overflow ? 1'b0 : ov1);
        m_cap  = done_flag && !m_prev;
        m_prev = done_flag;
    endtask

    task automatic check_models();
        logic [10:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : 11'd0;
        h1 = (q1.size() > 0) ? q1[0] : 11'd0;
        chk("keep_count",    32'(count0),    32'(q0.size()));
        chk("keep_valid",    32'(rd_valid0), 32'(q0.size() > 0));
        chk("keep_data",     32'(rd_data0),  32'(h0[7:0]));
        chk("keep_error",    32'(rd_error0), 32'(h0[10:8]));
        chk("keep_full",     32'(full0),     32'(q0.size() == DEPTH));
        chk("keep_empty",    32'(empty0),    32'(q0.size() == 0));
        chk("keep_overflow", 32'(overflow0), 32'(ov0));
        chk("drop_count",    32'(count1),    32'(q1.size()));
        chk("drop_data",     32'(rd_data1),  32'(h1[7:0]));
        chk("drop_error",    32'(rd_error1), 32'(h1[10:8]));
        chk("drop_full",     32'(full1),     32'(q1.size() == DEPTH));
        chk("drop_overflow", 32'(overflow1), 32'(ov1));
    endtask

    task automatic tick();
        @(posedge clock);
        if (rst) model_step();
        else model_reset();
        #1;
        check_models();
    endtask

    task automatic frame(input logic [7:0] d, input logic [2:0] e);
        done_flag = 1'b1; rx_data = d; rx_error = e;
        tick();
        done_flag = 1'b0;
        tick();
    endtask

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic [2:0] err;
        logic       rdy;
        int         exp_count;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [2:0] exp_err;
    } tv_t;

    tv_t vec[24];

    initial begin
        vec[0]  = '{1'b1, 8'hA5, 3'b000, 1'b0, 0, 1'b0, 8'h00, 3'b000};
        vec[1]  = '{1'b1, 8'hA5, 3'b000, 1'b0, 1, 1'b1, 8'hA5, 3'b000};
        for (int i = 2; i < 18; i++) vec[i] = '{1'b1, 8'hA5, 3'b000, 1'b0, 1, 1'b1, 8'hA5, 3'b000};
        vec[18] = '{1'b1, 8'hA5, 3'b000, 1'b1, 0, 1'b0, 8'h00, 3'b000};
        vec[19] = '{1'b1, 8'hA5, 3'b000, 1'b0, 0, 1'b0, 8'h00, 3'b000};
        vec[20] = '{1'b0, 8'hA5, 3'b000, 1'b0, 0, 1'b0, 8'h00, 3'b000};
        vec[21] = '{1'b1, 8'h3C, 3'b100, 1'b0, 0, 1'b0, 8'h00, 3'b000};
        vec[22] = '{1'b0, 8'h3C, 3'b100, 1'b0, 1, 1'b1, 8'h3C, 3'b100};
        vec[23] = '{1'b0, 8'h3C, 3'b100, 1'b1, 0, 1'b0, 8'h00, 3'b000};

        rst = 1'b0; done_flag = 1'b0; rx_data = 8'h00; rx_error = 3'b000;
        rd_ready = 1'b0; clr_overflow = 1'b0;
        model_reset();
        #1;
        check_models();
        repeat (2) @(posedge clock);
        #3 rst = 1'b1;

        // Asynchronous reset with entries queued
        frame(8'h11, 3'b000);
        frame(8'h22, 3'b001);
        chk("pre_reset_count", 32'(count0), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("async_count",    32'(count0),    32'd0);
        chk("async_valid",    32'(rd_valid0), 32'd0);
        chk("async_data",     32'(rd_data0),  32'd0);
        chk("async_empty",    32'(empty0),    32'd1);
        model_reset();
        tick();
        #2 rst = 1'b1;
        tick();

        // Directed vectors: single held frame, pop, errored frame
        foreach (vec[i]) begin
            done_flag = vec[i].done; rx_data = vec[i].data;
            rx_error = vec[i].err; rd_ready = vec[i].rdy;
            tick();
            chk($sformatf("vec%0d_count", i), 32'(count0),    32'(vec[i].exp_count));
            chk($sformatf("vec%0d_valid", i), 32'(rd_valid0), 32'(vec[i].exp_valid));
            chk($sformatf("vec%0d_data", i),  32'(rd_data0),  32'(vec[i].exp_data));
            chk($sformatf("vec%0d_err", i),   32'(rd_error0), 32'(vec[i].exp_err));
        end
        rd_ready = 1'b0; done_flag = 1'b0;
        tick();

        // Fill beyond capacity: 17th frame is lost
        for (int i = 0; i < 17; i++) frame(8'(i), 3'b000);
        tick();
        chk("fill_count",    32'(count0),    32'd16);
        chk("fill_full",     32'(full0),     32'd1);
        chk("fill_overflow", 32'(overflow0), 32'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill_read%0d", i), 32'(rd_data0), 32'(i));
            tick();
        end
        rd_ready = 1'b0;
        chk("fill_drained", 32'(empty0), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow0), 32'd0);

        // Full with simultaneous pop and push
        for (int i = 0; i < 16; i++) frame(8'h20 + 8'(i), 3'b000);
        done_flag = 1'b1; rx_data = 8'hEE;
        tick();
        done_flag = 1'b0; rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("pp_count",    32'(count0),    32'd16);
        chk("pp_overflow", 32'(overflow0), 32'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp_read%0d", i), 32'(rd_data0), (i == 15) ? 32'hEE : 32'(8'h21 + 8'(i)));
            tick();
        end
        rd_ready = 1'b0;

        // Errored frame: kept with tag vs dropped
        frame(8'h77, 3'b100);
        chk("err_keep_tag",   32'(rd_error0), 32'h4);
        chk("err_keep_data",  32'(rd_data0),  32'h77);
        chk("err_drop_count", 32'(count1),    32'd0);
        chk("err_drop_ovf",   32'(overflow1), 32'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        // Overflow set beats same-cycle clear
        for (int i = 0; i < 16; i++) frame(8'h40 + 8'(i), 3'b000);
        done_flag = 1'b1; rx_data = 8'h99;
        tick();
        done_flag = 1'b0; clr_overflow = 1'b1;
        tick();
        chk("ovf_set_wins", 32'(overflow0), 32'd1);
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clr_alone", 32'(overflow0), 32'd0);
        rd_ready = 1'b1;
        repeat (17) tick();

        // Randomised traffic, pointers wrap many times
        for (int i = 0; i < 600; i++) begin
            done_flag    = ($urandom_range(0, 2) != 0) ? ~done_flag : done_flag;
            rx_data      = 8'($urandom);
            rx_error     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            rd_ready     = ($urandom_range(0, 2) == 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
